packet_link_receiver: RTL and testbench

PACKET_LINK_RECEIVER -- requirements
Module: packet_link_receiver

---
 rtl/rx_link_pkg.sv | 16 +
 rtl/packet_link_receiver_if.sv | 29 ++
 rtl/rx_input_cond.sv | 60 ++++++
 rtl/packet_link_receiver.sv | 98 +++++++++
 tb/tb_packet_link_receiver.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rx_link_pkg.sv
// Shared definitions for the packet link receiver: message size, beat math, status type.
package rx_link_pkg;

    localparam int MESSAGE_SIZE = 100;

    // Number of DIN-wide beats needed to carry a msg_w-bit payload.
    function automatic int nbeats(input int msg_w, input int din_w);
        return (msg_w + din_w - 1) / din_w;
    endfunction

    typedef struct packed {
        logic msg_valid;
        logic frame_err;
    } rx_status_t;

endpackage

// File: rtl/packet_link_receiver_if.sv
// Link-side signal bundle for packet_link_receiver; master = remote board, slave = receiver.
interface packet_link_receiver_if #(
    parameter int MSG_W = rx_link_pkg::MESSAGE_SIZE,
    parameter int DIN_W = 6
) ();
    import rx_link_pkg::*;

    localparam int NBEATS = nbeats(MSG_W, DIN_W);
    localparam int BEAT_W = $clog2(NBEATS + 2);

    logic [DIN_W-1:0]  din;
    logic              packet_pulse;
    logic              transmit_ctrl;
    logic [MSG_W-1:0]  read_buffer;
    logic              msg_valid;
    logic              frame_err;
    logic [BEAT_W-1:0] beat_count;

    modport master (
        output din, packet_pulse, transmit_ctrl,
        input  read_buffer, msg_valid, frame_err, beat_count
    );

    modport slave (
        input  din, packet_pulse, transmit_ctrl,
        output read_buffer, msg_valid, frame_err, beat_count
    );

endinterface

// File: rtl/rx_input_cond.sv
// One asynchronous input: synchronizer chain, optional glitch filter (RX_GLITCH_FILTER_EN), rising-edge pulse.
module rx_input_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   synced;
    logic                   hist_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
        end
    end

    assign synced = sync_reg[SYNC_STAGES-1];

`ifdef RX_GLITCH_FILTER_EN
    logic       filt_reg;
    logic [4:0] run_reg;

    // run_reg counts consecutive samples disagreeing with the accepted level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_reg <= 1'b0;
            run_reg  <= '0;
        end else if (synced == filt_reg) begin
            run_reg <= '0;
        end else if (run_reg == 5'(FILTER_LEN - 1)) begin
            filt_reg <= synced;
            run_reg  <= '0;
        end else begin
            run_reg <= run_reg + 5'd1;
        end
    end

    assign level = filt_reg;
`else
    assign level = synced;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_reg <= 1'b0;
        end else begin
            hist_reg <= level;
        end
    end

    assign rise = level & ~hist_reg;

endmodule

// File: rtl/packet_link_receiver.sv
// Receives DIN-wide beats on asynchronous strobes, assembles a MSG_W payload, commits on transmit_ctrl.
// Glitch filtering on every input is enabled by defining RX_GLITCH_FILTER_EN.
module packet_link_receiver
    import rx_link_pkg::*;
#(
    parameter int MSG_W       = MESSAGE_SIZE,
    parameter int DIN_W       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    packet_link_receiver_if.slave  link
);
    localparam int NBEATS = nbeats(MSG_W, DIN_W);
    localparam int BUF_W  = NBEATS * DIN_W;
    localparam int BEAT_W = $clog2(NBEATS + 2);
    localparam int NIN    = DIN_W + 2;

    logic [NIN-1:0]    raw_in;
    logic [NIN-1:0]    level;
    logic [NIN-1:0]    rise;
    logic              beat_fire;
    logic              commit_fire;
    logic [BUF_W-1:0]  shifted;
    logic [BUF_W-1:0]  recv_buf_reg, recv_buf_next;
    logic [BEAT_W-1:0] beat_count_reg, beat_count_next;
    logic [MSG_W-1:0]  read_buffer_reg;
    rx_status_t        status_reg;

    // Bit layout: [DIN_W-1:0] data, [DIN_W] beat strobe, [DIN_W+1] commit strobe.
    assign raw_in = {link.transmit_ctrl, link.packet_pulse, link.din};

    generate
        for (genvar gi = 0; gi < NIN; gi++) begin : g_cond
            rx_input_cond #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILTER_LEN  (FILTER_LEN)
            ) u_cond (
                .clk      (clk),
                .rst_n    (rst_n),
                .async_in (raw_in[gi]),
                .level    (level[gi]),
                .rise     (rise[gi])
            );
        end

        if (NBEATS > 1) begin : g_shift
            assign shifted = {level[DIN_W-1:0], recv_buf_reg[BUF_W-1:DIN_W]};
        end else begin : g_single
            assign shifted = level[DIN_W-1:0];
        end
    endgenerate

    assign beat_fire   = rise[DIN_W];
    assign commit_fire = rise[DIN_W+1];

    // Beat is applied first so a coincident commit sees the updated frame.
    always_comb begin
        recv_buf_next   = recv_buf_reg;
        beat_count_next = beat_count_reg;
        if (beat_fire) begin
            recv_buf_next = shifted;
            if (beat_count_reg != BEAT_W'(NBEATS + 1)) begin
                beat_count_next = beat_count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            recv_buf_reg    <= '0;
            beat_count_reg  <= '0;
            read_buffer_reg <= '0;
            status_reg      <= '0;
        end else begin
            status_reg   <= '0;
            recv_buf_reg <= recv_buf_next;
            if (commit_fire) begin
                beat_count_reg <= '0;
                if (beat_count_next == BEAT_W'(NBEATS)) begin
                    read_buffer_reg      <= recv_buf_next[MSG_W-1:0];
                    status_reg.msg_valid <= 1'b1;
                end else begin
                    status_reg.frame_err <= 1'b1;
                end
            end else begin
                beat_count_reg <= beat_count_next;
            end
        end
    end

    assign link.read_buffer = read_buffer_reg;
    assign link.msg_valid   = status_reg.msg_valid;
    assign link.frame_err   = status_reg.frame_err;
    assign link.beat_count  = beat_count_reg;

endmodule

// File: tb/tb_packet_link_receiver.sv
// Scoreboard bench for packet_link_receiver with default parameters.
module tb_packet_link_receiver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    packet_link_receiver_if #(.MSG_W(100), .DIN_W(6)) link ();

    packet_link_receiver #(
        .MSG_W       (100),
        .DIN_W       (6),
        .SYNC_STAGES (2),
        .FILTER_LEN  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (link)
    );

    typedef struct {
        bit          is_msg;
        logic [99:0] data;
    } exp_t;

    exp_t         exp_q[$];
    int           total_checks = 0;
    int           bad_checks = 0;
    int           n_events = 0;
    logic [101:0] m_buf;
    int           m_cnt;
    logic [99:0]  m_good;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_beat(input logic [5:0] v);
        m_buf = {v, m_buf[101:6]};
        if (m_cnt < 18) m_cnt++;
    endfunction

    function automatic void model_commit();
        exp_t e;
        if (m_cnt == 17) begin
            m_good   = m_buf[99:0];
            e.is_msg = 1'b1;
        end else begin
            e.is_msg = 1'b0;
        end
        e.data = m_good;
        exp_q.push_back(e);
        m_cnt = 0;
    endfunction

    task automatic send_beat(input logic [5:0] v);
        link.din = v;
        cyc(2);
        link.packet_pulse = 1'b1;
        model_beat(v);
        cyc(6);
        link.packet_pulse = 1'b0;
        cyc(6);
    endtask

    task automatic send_commit();
        link.transmit_ctrl = 1'b1;
        model_commit();
        cyc(6);
        link.transmit_ctrl = 1'b0;
        cyc(6);
    endtask

    task automatic beat_and_commit(input logic [5:0] v);
        link.din = v;
        cyc(2);
        link.packet_pulse  = 1'b1;
        link.transmit_ctrl = 1'b1;
        model_beat(v);
        model_commit();
        cyc(6);
        link.packet_pulse  = 1'b0;
        link.transmit_ctrl = 1'b0;
        cyc(6);
    endtask

    // Output monitor: each status pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (link.msg_valid || link.frame_err)) begin
            n_events++;
            $display("commit %0d: msg_valid=%0b frame_err=%0b read_buffer=%0h",
                     n_events, link.msg_valid, link.frame_err, link.read_buffer);
            if (exp_q.size() == 0) begin
                check_value("unexpected_status", {link.msg_valid, link.frame_err}, 2'b00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_value("status_kind", {link.msg_valid, link.frame_err},
                            e.is_msg ? 2'b10 : 2'b01);
                check_value("read_buffer", link.read_buffer, e.data);
            end
        end
    end

    initial begin
        logic [99:0] rb;
        link.din           = '0;
        link.packet_pulse  = 1'b0;
        link.transmit_ctrl = 1'b0;
        m_buf  = '0;
        m_cnt  = 0;
        m_good = '0;

        rst_n = 1'b0;
        cyc(4);
        rst_n = 1'b1;
        cyc(2);
        check_value("rst_beat_count", link.beat_count, 0);
        check_value("rst_read_buffer", link.read_buffer, 0);
        check_value("rst_msg_valid", link.msg_valid, 0);
        check_value("rst_frame_err", link.frame_err, 0);

        // Good frame with beats 1..17
        for (int i = 1; i <= 17; i++) send_beat(6'(i));
        check_value("count_17", link.beat_count, 17);
        send_commit();
        rb = link.read_buffer;
        check_value("good_low_beat", rb[5:0], 6'h01);
        check_value("good_top_bits", rb[99:96], 4'h1);
        check_value("good_count_clr", link.beat_count, 0);

        // Short frame
        for (int i = 0; i < 16; i++) send_beat(6'($urandom_range(0, 63)));
        send_commit();
        check_value("short_count_clr", link.beat_count, 0);
        check_value("short_rb_held", link.read_buffer, m_good);

        // Long frame with saturation
        for (int i = 0; i < 18; i++) send_beat(6'($urandom_range(0, 63)));
        check_value("count_18", link.beat_count, 18);
        send_beat(6'h2a);
        check_value("count_sat", link.beat_count, 18);
        send_commit();
        check_value("long_count_clr", link.beat_count, 0);

        // 3-cycle glitch on the beat strobe
        link.din = 6'h15;
        cyc(2);
        link.packet_pulse = 1'b1;
        cyc(3);
        link.packet_pulse = 1'b0;
`ifndef RX_GLITCH_FILTER_EN
        model_beat(6'h15);
`endif
        cyc(12);
        check_value("glitch_count", link.beat_count, 32'(m_cnt));
        send_commit();

        // 17th beat coincident with commit
        for (int i = 0; i < 16; i++) send_beat(6'($urandom_range(0, 63)));
        beat_and_commit(6'h3c);
        check_value("simul_count_clr", link.beat_count, 0);
        check_value("simul_rb", link.read_buffer, m_good);

        // Reset mid-frame, then a clean frame
        for (int i = 0; i < 9; i++) send_beat(6'($urandom_range(0, 63)));
        check_value("count_9", link.beat_count, 9);
        rst_n = 1'b0;
        cyc(3);
        m_buf  = '0;
        m_cnt  = 0;
        m_good = '0;
        rst_n  = 1'b1;
        cyc(2);
        check_value("midrst_count", link.beat_count, 0);
        check_value("midrst_rb", link.read_buffer, 0);
        for (int i = 0; i < 17; i++) send_beat(6'($urandom_range(0, 63)));
        send_commit();
        check_value("post_rst_rb", link.read_buffer, m_good);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check_value("pending_expected", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
